// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan sequencer: walks a one-hot column strobe, freezes on a row hit,
// debounces press and release, and hands one key code per press to a valid/ready consumer.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// ST_SCAN     | stepping columns, looking for any row hit at each sample point
// ST_DEBOUNCE | column frozen, counting consecutive hits on the candidate row
// ST_PRESENT  | key_valid high, waiting for the consumer to take key_code
// ST_RELEASE  | column frozen, counting consecutive idle samples on the candidate row
module keypad_scan_ctrl #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] MATCH_DONE = CNT_W'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESENT  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       rows_m;
    logic [3:0]       rows_s;
    logic [DIV_W-1:0] dwell_cnt;
    logic [1:0]       col_idx;
    logic [1:0]       col_nxt;
    logic [1:0]       cand_row;
    logic [1:0]       cand_row_nxt;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] match_nxt;
    logic [CNT_W-1:0] match_inc;
    logic             valid_nxt;
    logic [3:0]       code_nxt;
    logic [1:0]       row_idx;
    logic             sample_pt;
    logic             cand_hit;

    // The column stays frozen outside ST_SCAN, so col_idx doubles as the candidate column.
    assign cols      = 4'b1000 >> col_idx;
    assign sample_pt = (dwell_cnt == DWELL_LAST);
    assign cand_hit  = rows_s[cand_row];
    assign match_inc = match_cnt + CNT_W'(1);

    always_comb begin
        row_idx = 2'd0;
        if (rows_s[0])      row_idx = 2'd0;
        else if (rows_s[1]) row_idx = 2'd1;
        else if (rows_s[2]) row_idx = 2'd2;
        else if (rows_s[3]) row_idx = 2'd3;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_m    <= 4'h0;
            rows_s    <= 4'h0;
            dwell_cnt <= '0;
        end else begin
            rows_m    <= rows;
            rows_s    <= rows_m;
            dwell_cnt <= sample_pt ? '0 : dwell_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_SCAN;
            col_idx   <= 2'd0;
            cand_row  <= 2'd0;
            match_cnt <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
        end else begin
            state     <= state_nxt;
            col_idx   <= col_nxt;
            cand_row  <= cand_row_nxt;
            match_cnt <= match_nxt;
            key_valid <= valid_nxt;
            key_code  <= code_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        col_nxt      = col_idx;
        cand_row_nxt = cand_row;
        match_nxt    = match_cnt;
        valid_nxt    = key_valid;
        code_nxt     = key_code;
        case (state)
            ST_SCAN: begin
                if (sample_pt) begin
                    if (rows_s == 4'h0) begin
                        col_nxt = col_idx + 2'd1;
                    end else begin
                        cand_row_nxt = row_idx;
                        match_nxt    = CNT_W'(1);
                        if (DEBOUNCE == 1) begin
                            state_nxt = ST_PRESENT;
                            valid_nxt = 1'b1;
                            code_nxt  = {row_idx, col_idx};
                        end else begin
                            state_nxt = ST_DEBOUNCE;
                        end
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (sample_pt) begin
                    if (cand_hit) begin
                        match_nxt = match_inc;
                        if (match_inc == MATCH_DONE) begin
                            state_nxt = ST_PRESENT;
                            valid_nxt = 1'b1;
                            code_nxt  = {cand_row, col_idx};
                        end
                    end else begin
                        state_nxt = ST_SCAN;
                        col_nxt   = col_idx + 2'd1;
                    end
                end
            end
            ST_PRESENT: begin
                if (key_valid && key_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = ST_RELEASE;
                    match_nxt = '0;
                end
            end
            ST_RELEASE: begin
                if (sample_pt) begin
                    if (cand_hit) begin
                        match_nxt = '0;
                    end else if (match_inc == MATCH_DONE) begin
                        state_nxt = ST_SCAN;
                        col_nxt   = col_idx + 2'd1;
                        match_nxt = '0;
                    end else begin
                        match_nxt = match_inc;
                    end
                end
            end
            default: state_nxt = ST_SCAN;
        endcase
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad model on the pins plus a procedural reference
// model of the scan/debounce/handshake sequence, compared every cycle and per scenario.
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;

    logic [3:0] kp_rows;
    logic [1:0] kp_col;

    int checks = 0;
    int errors = 0;

    logic [1:0]  m_col;
    logic        m_valid;
    logic [3:0]  m_code;
    logic [3:0]  m_s1;
    logic [3:0]  m_s2;
    int unsigned m_edge;
    bit          m_abort;

    keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready)
    );

    always #5 clk = ~clk;

    // Keypad: the pressed key's rows connect only while its column is driven.
    assign rows = (cols == (4'b1000 >> kp_col)) ? kp_rows : 4'h0;

    function automatic int lowest(input logic [3:0] v);
        int lo = 0;
        for (int b = 3; b >= 0; b--) if (v[b]) lo = b;
        return lo;
    endfunction

    task automatic model_clear();
        m_col   = 2'd0;
        m_valid = 1'b0;
        m_code  = 4'h0;
        m_s1    = 4'h0;
        m_s2    = 4'h0;
        m_edge  = 0;
    endtask

    task automatic edge_step(output logic [3:0] rs, output bit smp, output bit rdy);
        logic [3:0] pre;
        rs  = 4'h0;
        smp = 1'b0;
        rdy = 1'b0;
        @(posedge clk or posedge reset);
        if (reset) begin
            m_abort = 1'b1;
            model_clear();
            return;
        end
        pre    = (m_col == kp_col) ? kp_rows : 4'h0;
        rdy    = key_ready;
        rs     = m_s2;
        m_s2   = m_s1;
        m_s1   = pre;
        m_edge = m_edge + 1;
        smp    = (m_edge % SCAN_DIV) == 0;
    endtask

    task automatic model_run();
        logic [3:0] rs;
        bit smp;
        bit rdy;
        int crow;
        int cnt;
        forever begin
            forever begin
                edge_step(rs, smp, rdy);
                if (m_abort) return;
                if (smp && rs != 4'h0) break;
                if (smp) m_col = m_col + 2'd1;
            end
            crow = lowest(rs);
            cnt  = 1;
            while (cnt < DEBOUNCE) begin
                edge_step(rs, smp, rdy);
                if (m_abort) return;
                if (smp) begin
                    if (rs[crow]) cnt++;
                    else break;
                end
            end
            if (cnt < DEBOUNCE) begin
                m_col = m_col + 2'd1;
                continue;
            end
            m_code  = {2'(crow), m_col};
            m_valid = 1'b1;
            rdy = 1'b0;
            while (!rdy) begin
                edge_step(rs, smp, rdy);
                if (m_abort) return;
            end
            m_valid = 1'b0;
            cnt     = 0;
            while (cnt < DEBOUNCE) begin
                edge_step(rs, smp, rdy);
                if (m_abort) return;
                if (smp) cnt = rs[crow] ? 0 : cnt + 1;
            end
            m_col = m_col + 2'd1;
        end
    endtask

    initial begin : model
        model_clear();
        forever begin
            wait (reset === 1'b0);
            m_abort = 1'b0;
            m_edge  = 0;
            model_run();
        end
    end

    always @(negedge clk) begin : model_monitor
        checks++;
        if (cols !== (4'b1000 >> m_col) || key_valid !== m_valid || key_code !== m_code) begin
            errors++;
            if (errors < 30)
                $display("FAIL model_track t=%0t cols=%b want %b valid=%b want %b code=%h want %h",
                         $time, cols, 4'b1000 >> m_col, key_valid, m_valid, key_code, m_code);
        end
    end

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        reset = 1'b1; key_ready = 1'b1; kp_rows = 4'h0; kp_col = 2'd0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (cols !== 4'b1000 || key_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_state cols=%b valid=%b want 1000/0", cols, key_valid);
            end
        end
        reset = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            exp = 4'b1000 >> ((n / SCAN_DIV) % 4);
            checks++;
            if (cols !== exp || key_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_scan n=%0d cols=%b want %b valid=%b", n, cols, exp, key_valid);
            end
        end
    endtask

    task automatic test_press();
        bit ok;
        @(negedge clk);
        kp_col = 2'd2; kp_rows = 4'b0010; key_ready = 1'b1;
        wait_valid(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL press_timeout valid=%b want 1", key_valid); end
        checks++;
        if (key_code !== 4'b0110 || cols !== 4'b0010) begin
            errors++;
            $display("FAIL press_code code=%b cols=%b want 0110/0010", key_code, cols);
        end
        @(negedge clk);
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL press_pulse valid=%b want 0", key_valid); end
        kp_rows = 4'h0;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_glitch();
        bit ok = 1'b0;
        kp_col = 2'd1; kp_rows = 4'h0;
        for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); if (cols !== 4'b0100) ok = 1'b1; end
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); if (cols === 4'b0100) ok = 1'b1; end
        checks++;
        if (!ok) begin errors++; $display("FAIL glitch_sync cols=%b want 0100", cols); end
        kp_rows = 4'b0001 << $urandom_range(3, 0);
        repeat (SCAN_DIV) @(negedge clk);
        kp_rows = 4'h0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            checks++;
            if (key_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid valid=%b want 0", key_valid); end
            if (cols !== 4'b0100) ok = 1'b1;
        end
        checks++;
        if (cols !== 4'b0010) begin errors++; $display("FAIL glitch_resume cols=%b want 0010", cols); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_hold();
        bit ok;
        int r = $urandom_range(3, 0);
        int c = $urandom_range(3, 0);
        logic [3:0] exp_code = {2'(r), 2'(c)};
        logic [3:0] exp_next = 4'b1000 >> ((c + 1) % 4);
        @(negedge clk);
        key_ready = 1'b0; kp_col = 2'(c); kp_rows = 4'b0001 << r;
        wait_valid(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hold_timeout valid=%b want 1", key_valid); end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 5) kp_rows = 4'h0;
            checks++;
            if (key_valid !== 1'b1 || key_code !== exp_code || cols !== (4'b1000 >> c)) begin
                errors++;
                $display("FAIL hold_stable i=%0d valid=%b code=%b cols=%b want 1/%b/%b",
                         i, key_valid, key_code, cols, exp_code, 4'b1000 >> c);
            end
        end
        key_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL hold_accept valid=%b want 0", key_valid); end
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); if (cols !== (4'b1000 >> c)) ok = 1'b1; end
        checks++;
        if (cols !== exp_next) begin errors++; $display("FAIL hold_resume cols=%b want %b", cols, exp_next); end
    endtask

    task automatic test_multi_row();
        bit ok;
        @(negedge clk);
        kp_col = 2'd0; kp_rows = 4'b0101; key_ready = 1'b1;
        wait_valid(200, ok);
        checks++;
        if (!ok || key_code !== 4'b0000) begin
            errors++;
            $display("FAIL multi_row ok=%b code=%b want 1/0000", ok, key_code);
        end
        kp_rows = 4'h0;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset_present();
        bit ok;
        logic [3:0] exp;
        @(negedge clk);
        key_ready = 1'b0; kp_col = 2'($urandom_range(3, 0)); kp_rows = 4'b0001 << $urandom_range(3, 0);
        wait_valid(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rstp_timeout valid=%b want 1", key_valid); end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (key_valid !== 1'b0 || cols !== 4'b1000) begin
            errors++;
            $display("FAIL rstp_async valid=%b cols=%b want 0/1000", key_valid, cols);
        end
        kp_rows = 4'h0;
        @(negedge clk);
        reset = 1'b0; key_ready = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            exp = 4'b1000 >> ((n / SCAN_DIV) % 4);
            checks++;
            if (cols !== exp || key_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstp_restart n=%0d cols=%b want %b valid=%b", n, cols, exp, key_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int k = 0; k < 6; k++) begin
            int c = $urandom_range(3, 0);
            logic [3:0] mask = 4'($urandom_range(15, 1));
            logic [3:0] exp_code = {2'(lowest(mask)), 2'(c)};
            @(negedge clk);
            key_ready = 1'b0; kp_col = 2'(c); kp_rows = mask;
            wait_valid(200, ok);
            checks++;
            if (!ok || key_code !== exp_code) begin
                errors++;
                $display("FAIL b2b_code k=%0d ok=%b code=%b want %b", k, ok, key_code, exp_code);
            end
            repeat ($urandom_range(10, 0)) @(negedge clk);
            if ($urandom_range(1, 0) == 1) kp_rows = 4'h0;
            key_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (key_valid !== 1'b0) begin errors++; $display("FAIL b2b_accept k=%0d valid=%b want 0", k, key_valid); end
            kp_rows = 4'h0;
            repeat ($urandom_range(30, 16)) @(negedge clk);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_hold();
        test_multi_row();
        test_reset_present();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
